// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared AES constants, types and GF(2^8) helper functions.
//                Used by the key-schedule engine and the S-box stage.
//                Contents:
//                  NK128/NK192/NK256  legal key lengths in 32-bit words
//                  nr_of(nk)          number of rounds for a key length
//                  xtime(x)           multiply by x in GF(2^8)
//                  sbox(x)            AES forward S-box, computed arithmetically
//                  word_t             32-bit schedule word
//  Revision    : 1.0  initial release
// ============================================================================
package aes_pkg;

  localparam int NK128 = 4;
  localparam int NK192 = 6;
  localparam int NK256 = 8;

  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;

  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } ke_state_e;

  function automatic int nr_of(input int nk);
    return nk + 6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] t;
    acc = 8'h00;
    t   = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc = acc ^ t;
      t = xtime(t);
    end
    return acc;
  endfunction

  // Multiplicative inverse as x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  // Inverse followed by the FIPS-197 affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sub_table.sv
`default_nettype none
// ============================================================================
//  Module      : aes_sub_table
//  Description : Single-byte AES forward S-box (SubTable), purely
//                combinational. Shared by SubBytes and SubWord.
//  Ports       : in_byte  [7:0]  input byte
//                out_byte [7:0]  substituted byte
//  Revision    : 1.0  initial release
// ============================================================================
module aes_sub_table
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  assign out_byte = sbox(in_byte);

endmodule
`default_nettype wire

// File: rtl/aes_sub_word.sv
`default_nettype none
// ============================================================================
//  Module      : aes_sub_word
//  Description : 32-bit combinational SubWord: four SubTable byte S-boxes
//                applied independently to each byte of the word.
//  Ports       : word_in  [31:0]  input word
//                word_out [31:0]  byte-wise substituted word
//  Revision    : 1.0  initial release
// ============================================================================
module aes_sub_word
  import aes_pkg::*;
(
  input  word_t word_in,
  output word_t word_out
);

  for (genvar g = 0; g < 4; g++) begin : g_byte
    aes_sub_table u_sub_table (
      .in_byte  (word_in[8*g +: 8]),
      .out_byte (word_out[8*g +: 8])
    );
  end

endmodule
`default_nettype wire

// File: rtl/aes_key_expand.sv
`default_nettype none
// ============================================================================
//  Module      : aes_key_expand
//  Description : Iterative AES key schedule. One 32-bit schedule word is
//                produced per cycle; every fourth word completes a 128-bit
//                round key that is offered on a valid/ready stream.
//                Build option KEY_EXP_ZEROIZE_EN: when defined, the word
//                buffer, collector, rk and rcon are cleared on the edge that
//                raises done, so no key material remains after expansion.
//  Ports       : clk        rising-edge clock
//                rst_n      asynchronous active-low reset
//                start      begin expansion (sampled only while idle)
//                key        cipher key, key[32*NK-1 -: 32] = w[0]
//                busy       expansion in progress
//                rk_valid   rk / rk_round valid
//                rk_ready   downstream accepts rk
//                rk         round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}
//                rk_round   round index r, 0..NR
//                done       one-cycle pulse after the final handshake
//  Revision    : 1.0  initial release
// ============================================================================
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [32*NK-1:0] key,
  output logic            busy,
  output logic            rk_valid,
  input  logic            rk_ready,
  output logic [127:0]    rk,
  output logic [3:0]      rk_round,
  output logic            done
);

  localparam int         NR      = nr_of(NK);
  localparam logic [3:0] NR_IDX  = 4'(NR);
  localparam logic [5:0] NK_W    = 6'(NK);
  localparam logic [2:0] PH_LAST = 3'(NK - 1);

  if (NK != NK128 && NK != NK192 && NK != NK256) begin : g_bad_nk
    $error("aes_key_expand: NK must be 4, 6 or 8");
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  ke_state_e               state_q,    state_d;
  logic [5:0]              i_q,        i_d;        // schedule word index
  logic [2:0]              ph_q,       ph_d;       // i mod NK
  logic [7:0]              rcon_q,     rcon_d;
  logic [NK-1:0][31:0]     buf_q,      buf_d;      // [0] = w[i-NK], [NK-1] = w[i-1]
  logic [95:0]             col_q,      col_d;      // last three words of the round
  logic [127:0]            rk_q,       rk_d;
  logic [3:0]              rk_round_q, rk_round_d;
  logic                    rk_valid_q, rk_valid_d;
  logic                    done_q,     done_d;

  // --------------------------------------------------------------------------
  // Word generation datapath
  // --------------------------------------------------------------------------
  word_t w_prev;
  word_t w_old;
  word_t sub_in;
  word_t sub_out;
  word_t new_word;
  logic  in_key;
  logic  rcon_word;

  assign w_prev    = buf_q[NK-1];
  assign w_old     = buf_q[0];
  assign in_key    = (i_q < NK_W);
  assign rcon_word = !in_key && (ph_q == 3'd0);
  // RotWord is applied ahead of SubWord only on rcon words.
  assign sub_in    = rcon_word ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  aes_sub_word u_sub_word (
    .word_in  (sub_in),
    .word_out (sub_out)
  );

  always_comb begin
    // While i < NK the key words circulate through the buffer unchanged, so
    // after NK steps the buffer again holds w[0..NK-1] in order.
    new_word = w_old ^ w_prev;
    if (in_key) begin
      new_word = w_old;
    end else if (ph_q == 3'd0) begin
      new_word = w_old ^ sub_out ^ {rcon_q, 24'h0};
    end else if (NK == NK256 && ph_q == 3'd4) begin
      new_word = w_old ^ sub_out;
    end
  end

  // --------------------------------------------------------------------------
  // Control
  // --------------------------------------------------------------------------
  logic advance;
  logic final_pending;
  logic gen;
  logic handshake;
  logic final_hs;
  logic load_rk;

  assign advance       = (state_q == ST_EXPAND) && !(rk_valid_q && !rk_ready);
  // Once round NR has been loaded every word has been generated; only the
  // final handshake remains.
  assign final_pending = rk_valid_q && (rk_round_q == NR_IDX);
  assign gen           = advance && !final_pending;
  assign handshake     = rk_valid_q && rk_ready;
  assign final_hs      = (state_q == ST_EXPAND) && handshake && final_pending;
  assign load_rk       = gen && (i_q[1:0] == 2'b11);

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    ph_d       = ph_q;
    rcon_d     = rcon_q;
    buf_d      = buf_q;
    col_d      = col_q;
    rk_d       = rk_q;
    rk_round_d = rk_round_q;
    rk_valid_d = rk_valid_q;
    done_d     = final_hs;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_EXPAND;
          i_d     = 6'd0;
          ph_d    = 3'd0;
          rcon_d  = RCON_INIT;
          for (int k = 0; k < NK; k++) begin
            buf_d[k] = key[32*(NK-k)-1 -: 32];
          end
        end
      end
      ST_EXPAND: begin
        if (final_hs) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (gen) begin
      i_d   = i_q + 6'd1;
      ph_d  = (ph_q == PH_LAST) ? 3'd0 : ph_q + 3'd1;
      buf_d = {new_word, buf_q[NK-1:1]};
      col_d = {col_q[63:0], new_word};
      if (rcon_word) begin
        rcon_d = xtime(rcon_q);
      end
    end

    if (load_rk) begin
      rk_d       = {col_q, new_word};
      rk_round_d = i_q[5:2];
      rk_valid_d = 1'b1;
    end else if (handshake) begin
      rk_valid_d = 1'b0;
    end

`ifdef KEY_EXP_ZEROIZE_EN
    if (final_hs) begin
      buf_d  = '0;
      col_d  = '0;
      rk_d   = '0;
      rcon_d = 8'h00;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      i_q        <= 6'd0;
      ph_q       <= 3'd0;
      rcon_q     <= 8'h00;
      buf_q      <= '0;
      col_q      <= '0;
      rk_q       <= '0;
      rk_round_q <= 4'd0;
      rk_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      ph_q       <= ph_d;
      rcon_q     <= rcon_d;
      buf_q      <= buf_d;
      col_q      <= col_d;
      rk_q       <= rk_d;
      rk_round_q <= rk_round_d;
      rk_valid_q <= rk_valid_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q == ST_EXPAND);
  assign rk_valid = rk_valid_q;
  assign rk       = rk_q;
  assign rk_round = rk_round_q;
  assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expand.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_key_expand
//  Description : Self-checking bench for aes_key_expand with NK = 4, 6, 8.
//                A stand-alone key-schedule model fills a scoreboard; a
//                monitor pops and compares on every rk handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_aes_key_expand;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [2:0]   start;
  logic [2:0]   rk_ready;
  logic [2:0]   busy;
  logic [2:0]   rk_valid;
  logic [2:0]   done;
  logic [127:0] key4;
  logic [191:0] key6;
  logic [255:0] key8;
  logic [127:0] rk_a [3];
  logic [3:0]   rk_round_a [3];

  aes_key_expand #(.NK(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .key(key4), .busy(busy[0]),
    .rk_valid(rk_valid[0]), .rk_ready(rk_ready[0]), .rk(rk_a[0]),
    .rk_round(rk_round_a[0]), .done(done[0]));

  aes_key_expand #(.NK(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .key(key6), .busy(busy[1]),
    .rk_valid(rk_valid[1]), .rk_ready(rk_ready[1]), .rk(rk_a[1]),
    .rk_round(rk_round_a[1]), .done(done[1]));

  aes_key_expand #(.NK(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .key(key8), .busy(busy[2]),
    .rk_valid(rk_valid[2]), .rk_ready(rk_ready[2]), .rk(rk_a[2]),
    .rk_round(rk_round_a[2]), .done(done[2]));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: S-box table generated by walking the generator 3 and
  // its inverse, then a word-level schedule straight from the FIPS rules.
  // --------------------------------------------------------------------------
  logic [7:0]   sbox_t [256];
  logic [31:0]  mw [60];
  logic [127:0] exp_rk [15];
  logic [127:0] dut_rk [15];

  function automatic int rotl8(input int x, input int s);
    return ((x << s) | (x >> (8 - s))) & 255;
  endfunction

  task automatic build_sbox();
    int p, q, x;
    p = 1;
    q = 1;
    do begin
      p = (p ^ (p << 1) ^ (((p & 128) != 0) ? 27 : 0)) & 255;
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      q = q & 255;
      if ((q & 128) != 0) q = q ^ 9;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_t[p] = 8'(x ^ 99);
    end while (p != 1);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
  endfunction

  task automatic build_model(input int nk, input logic [255:0] k);
    int nr, rc;
    logic [31:0] t;
    nr = nk + 6;
    rc = 1;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) begin
        mw[i] = k[32*nk-1-32*i -: 32];
      end else begin
        t = mw[i-1];
        if (i % nk == 0) begin
          t  = sub_word({t[23:0], t[31:24]}) ^ {rc[7:0], 24'h0};
          rc = rc * 2;
          if (rc > 255) rc = rc ^ 'h11b;
        end else if (nk == 8 && i % nk == 4) begin
          t = sub_word(t);
        end
        mw[i] = mw[i-nk] ^ t;
      end
    end
    for (int r = 0; r <= nr; r++) exp_rk[r] = {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endtask

  // --------------------------------------------------------------------------
  // Scoreboard and monitor
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [3:0]   rnd;
    logic [127:0] key;
  } exp_t;

  exp_t sb_q [$];
  exp_t mon_e;

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst_n && rk_valid[d] && rk_ready[d]) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rk dut=%0d actual_round=%0d required=none", d, rk_round_a[d]);
        end else begin
          mon_e = sb_q.pop_front();
          check("rk_stream", {4'h0, rk_round_a[d], rk_a[d]}, {4'h0, mon_e.rnd, mon_e.key});
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // One expansion run on DUT d. Cycle m counts from the accept edge: m=1 is
  // the first cycle after start was taken.
  // --------------------------------------------------------------------------
  task automatic run(input int d, input logic [255:0] k, input int stall_round,
                     input int stall_len, input int rst_round, input int mid_start,
                     input bit rand_rdy);
    int nk, nr, m, first, donem, bound;
    bit rst_hit;
    nk      = 4 + 2 * d;
    nr      = nk + 6;
    first   = -1;
    donem   = -1;
    rst_hit = 1'b0;
    bound   = rand_rdy ? 600 : 6 + 4 * nr + stall_len + 4;
    build_model(nk, k);
    for (int r = 0; r < 15; r++) dut_rk[r] = '0;
    for (int r = 0; r <= nr; r++) sb_q.push_back({4'(r), exp_rk[r]});

    @(posedge clk); #1;
    case (d)
      0:       key4 = k[127:0];
      1:       key6 = k[191:0];
      default: key8 = k;
    endcase
    start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
    m = 1;
    while (m <= bound) begin
      if (rand_rdy) rk_ready[d] = ($urandom_range(0, 3) != 0);
      else rk_ready[d] = !(stall_len > 0 && m >= 5 + 4 * stall_round &&
                           m < 5 + 4 * stall_round + stall_len);
      if (m == 1) check("busy_after_start", {135'h0, busy[d]}, 136'h1);
      if (rk_valid[d] && first < 0) first = m;
      if (rk_valid[d]) dut_rk[rk_round_a[d]] = rk_a[d];
      if (!rand_rdy && !rk_ready[d] && rk_valid[d])
        check("stall_hold", {4'h0, rk_round_a[d], rk_a[d]}, {4'h0, 4'(stall_round), exp_rk[stall_round]});
      if (mid_start > 0 && m == mid_start) begin
        start[d] = 1'b1;
        key8 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        key4 = key8[127:0];
        key6 = key8[191:0];
      end else begin
        start[d] = 1'b0;
      end
      if (done[d]) begin
        donem = m;
        break;
      end
      if (rst_round >= 0 && m == 5 + 4 * rst_round) begin
        rst_n = 1'b0;
        #1;
        check("reset_midrun_outputs",
              {1'b0, busy[d], rk_valid[d], done[d], rk_round_a[d], rk_a[d]}, 136'h0);
        sb_q.delete();
        rst_hit = 1'b1;
        break;
      end
      @(posedge clk); #1;
      m++;
    end
    start[d] = 1'b0;

    if (first >= 0) check("first_valid_latency", 136'(first), 136'd5);

    if (rst_hit) begin
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      rk_ready[d] = 1'b1;
      repeat (6) begin
        @(posedge clk); #1;
        check("idle_after_reset", {134'h0, busy[d], rk_valid[d]}, 136'h0);
      end
    end else if (donem < 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout dut=%0d actual=no_done required=done_within_%0d", d, bound);
      rk_ready[d] = 1'b1;
    end else begin
      rk_ready[d] = 1'b1;
      if (!rand_rdy) check("done_latency", 136'(donem), 136'(6 + 4 * nr + stall_len));
      check("busy_at_done", {135'h0, busy[d]}, 136'h0);
`ifdef KEY_EXP_ZEROIZE_EN
      check("rk_after_done", {7'h0, rk_valid[d], rk_a[d]}, 136'h0);
`else
      check("rk_after_done", {7'h0, rk_valid[d], rk_a[d]}, {8'h0, exp_rk[nr]});
`endif
      check("scoreboard_drained", 136'(sb_q.size()), 136'h0);
      @(posedge clk); #1;
      check("done_one_pulse", {135'h0, done[d]}, 136'h0);
    end
  endtask

  localparam logic [255:0] KEY1 = 256'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] KEY2 = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] KEY3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  initial begin
    logic [255:0] rk_key;
    build_sbox();
    rst_n    = 1'b0;
    start    = 3'b000;
    rk_ready = 3'b111;
    key4     = '0;
    key6     = '0;
    key8     = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++)
      check("reset_state", {1'b0, busy[d], rk_valid[d], done[d], rk_round_a[d], rk_a[d]}, 136'h0);
    rst_n = 1'b1;

    run(0, KEY1, 0, 0, -1, 0, 1'b0);
    check("kat128_round1",  {8'h0, dut_rk[1]},  {8'h0, 128'ha0fafe1788542cb123a339392a6c7605});
    check("kat128_round10", {8'h0, dut_rk[10]}, {8'h0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});

    run(1, KEY2, 0, 0, -1, 0, 1'b0);
    check("kat192_round12", {8'h0, dut_rk[12]}, {8'h0, 128'he98ba06f448c773c8ecc720401002202});

    run(2, KEY3, 0, 0, -1, 0, 1'b0);
    check("kat256_round14", {8'h0, dut_rk[14]}, {8'h0, 128'hfe4890d1e6188d0b046df344706c631e});

    run(0, KEY1, 3, 5, -1, 0, 1'b0);
    run(0, KEY1, 0, 0, -1, 10, 1'b0);
    run(0, KEY1, 0, 0, 5, 0, 1'b0);
    run(0, KEY1, 0, 0, -1, 0, 1'b0);
    check("kat128_after_reset", {8'h0, dut_rk[10]}, {8'h0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});

    for (int n = 0; n < 2; n++) begin
      for (int d = 0; d < 3; d++) begin
        rk_key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        if (d == 0) rk_key[255:128] = '0;
        if (d == 1) rk_key[255:192] = '0;
        run(d, rk_key, 0, 0, -1, 0, 1'b1);
      end
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
